dmem_write_buffer: RTL and testbench

DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

---
 rtl/arm_mem_pkg.sv | 22 ++
 rtl/dmem_write_buffer_if.sv | 19 +
 rtl/wbuf_fifo.sv | 79 +++++++
 rtl/dmem_write_buffer.sv | 141 ++++++++++++++
 tb/tb_dmem_write_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the data-memory write buffer.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_READ  = 2'd2,
    ST_RDONE = 2'd3
  } bus_state_e;

  localparam int unsigned WBUF_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  function automatic logic [31:0] word_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Memory bus between the write buffer (master) and the memory controller (slave).
interface dmem_write_buffer_if;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic        BusAck;
  logic [31:0] BusRData;

  modport master (
    output BusReq, BusWe, BusAddr, BusWData,
    input  BusAck, BusRData
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWData,
    output BusAck, BusRData
  );
endinterface

// File: rtl/wbuf_fifo.sv
// Circular store queue with youngest-match lookup for load forwarding.
module wbuf_fifo
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wbuf_entry_t              push_entry,
  input  logic                     pop,
  input  logic [29:0]              lookup_addr,
  output wbuf_entry_t              head_entry,
  output wbuf_entry_t              next_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     hit,
  output logic [31:0]              hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  wbuf_entry_t       mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     head_nxt;
  logic [PW-1:0]     idx;

  assign head_nxt   = head + 1'b1;
  assign head_entry = mem[head];
  assign next_entry = mem[head_nxt];
  assign full       = (count == FULL_CNT);

  // Push never targets the head slot while popping: push is blocked when full
  // and pop only happens when non-empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + i[PW-1:0];
      if (valid[idx] && (mem[idx].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the M stage and the memory bus, with load forwarding.
module dmem_write_buffer
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWriteM,
  input  logic                       MemReadM,
  input  logic [31:0]                ALUResultM,
  input  logic [31:0]                WriteDataM,
  output logic [31:0]                ReadDataM,
  output logic                       StallMem,
  dmem_write_buffer_if.master        bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  bus_state_e      state;
  logic [31:0]     rdata_q;

  wbuf_entry_t     push_entry;
  wbuf_entry_t     head_entry;
  wbuf_entry_t     next_entry;
  logic [CW-1:0]   count;
  logic            full;
  logic            hit;
  logic [31:0]     hit_data;

  logic            load_req;
  logic            load_miss;
  logic            push;
  logic            pop;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^ALUResultM[1:0];

  assign load_req   = MemReadM && !MemWriteM;
  assign load_miss  = load_req && !hit;
  assign push_entry = '{addr: ALUResultM[31:2], data: WriteDataM};

  // In RDONE the held load is satisfied from rdata_q, so it no longer stalls.
  assign StallMem = reset &&
                    ((MemWriteM && full) || (load_miss && (state != ST_RDONE)));
  assign push     = MemWriteM && !StallMem;
  assign pop      = (state == ST_DRAIN) && bus.BusReq && bus.BusAck;

  always_comb begin
    ReadDataM = '0;
    if (state == ST_RDONE) ReadDataM = rdata_q;
    else if (load_req && hit) ReadDataM = hit_data;
  end

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .lookup_addr (ALUResultM[31:2]),
    .head_entry  (head_entry),
    .next_entry  (next_entry),
    .count       (count),
    .full        (full),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rdata_q      <= '0;
      bus.BusReq   <= 1'b0;
      bus.BusWe    <= 1'b0;
      bus.BusAddr  <= '0;
      bus.BusWData <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_miss) begin
            state        <= ST_READ;
            bus.BusReq   <= 1'b1;
            bus.BusWe    <= 1'b0;
            bus.BusAddr  <= word_addr(ALUResultM[31:2]);
            bus.BusWData <= '0;
          end else if (count != '0) begin
            state        <= ST_DRAIN;
            bus.BusReq   <= 1'b1;
            bus.BusWe    <= 1'b1;
            bus.BusAddr  <= word_addr(head_entry.addr);
            bus.BusWData <= head_entry.data;
          end
        end
        ST_DRAIN: begin
          if (bus.BusAck) begin
            if (load_miss) begin
              state        <= ST_READ;
              bus.BusWe    <= 1'b0;
              bus.BusAddr  <= word_addr(ALUResultM[31:2]);
              bus.BusWData <= '0;
            end else if (count > CNT_ONE) begin
              // Head is popped at this edge, so the following entry goes out next.
              bus.BusAddr  <= word_addr(next_entry.addr);
              bus.BusWData <= next_entry.data;
            end else begin
              state      <= ST_IDLE;
              bus.BusReq <= 1'b0;
              bus.BusWe  <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (bus.BusAck) begin
            state      <= ST_RDONE;
            rdata_q    <= bus.BusRData;
            bus.BusReq <= 1'b0;
          end
        end
        ST_RDONE: begin
          if (count != '0) begin
            state        <= ST_DRAIN;
            bus.BusReq   <= 1'b1;
            bus.BusWe    <= 1'b1;
            bus.BusAddr  <= word_addr(head_entry.addr);
            bus.BusWData <= head_entry.data;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          bus.BusReq <= 1'b0;
          bus.BusWe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a scoreboard of expected bus writes.
module tb_dmem_write_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;

  dmem_write_buffer_if bus_if ();

  dmem_write_buffer #(.DEPTH(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .bus        (bus_if)
  );

  int  checks = 0;
  int  errors = 0;
  int  nwrites = 0;
  int  nreads = 0;
  int  rd_cycles = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard the bus at the end of the current cycle, then advance one clock.
  task automatic cyc();
    wr_t e;
    if (bus_if.BusReq && !bus_if.BusWe) rd_cycles++;
    if (bus_if.BusReq && bus_if.BusAck) begin
      if (bus_if.BusWe) begin
        nwrites++;
        chk("sb_write_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_write_addr", bus_if.BusAddr, e.addr);
          chk("sb_write_data", bus_if.BusWData, e.data);
        end
      end else begin
        nreads++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    MemWriteM  = 1'b1;
    MemReadM   = 1'b0;
    ALUResultM = a;
    WriteDataM = d;
    #1;
    chk("store_no_stall", 32'(StallMem), 32'd0);
    e.addr = a & 32'hFFFF_FFFC;
    e.data = d;
    exp_q.push_back(e);
    cyc();
    MemWriteM = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !bus_if.BusReq && u_dut.u_fifo.count == '0) break;
      bus_if.BusAck = bus_if.BusReq;
      #1;
      cyc();
    end
    bus_if.BusAck = 1'b0;
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(bus_if.BusReq), 32'd0);
  endtask

  initial begin
    int  rd0;
    int  nw0;
    logic wrapped;
    logic [1:0] prev_tail;
    wr_t e;

    reset = 1'b1;
    MemWriteM = 1'b0;
    MemReadM = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    bus_if.BusAck = 1'b0;
    bus_if.BusRData = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busreq", 32'(bus_if.BusReq), 32'd0);
    chk("rst_stall", 32'(StallMem), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_count", 32'(u_dut.u_fifo.count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();

    // Fill to DEPTH with no acknowledge, then a fifth store must stall.
    put(32'h100, 32'hA0A0_0001);
    put(32'h104, 32'hB0B0_0002);
    put(32'h108, 32'hC0C0_0003);
    put(32'h10C, 32'hD0D0_0004);
    MemWriteM = 1'b1; ALUResultM = 32'h110; WriteDataM = 32'hE0E0_0005;
    #1;
    chk("full_count", 32'(u_dut.u_fifo.count), 32'd4);
    chk("full_stall", 32'(StallMem), 32'd1);
    chk("full_head_addr", bus_if.BusAddr, 32'h100);
    chk("full_head_data", bus_if.BusWData, 32'hA0A0_0001);
    cyc();
    chk("full_stall_hold", 32'(StallMem), 32'd1);
    bus_if.BusAck = 1'b1;
    #1;
    chk("full_stall_on_ack", 32'(StallMem), 32'd1);
    cyc();
    bus_if.BusAck = 1'b0;
    #1;
    chk("fifth_accept", 32'(StallMem), 32'd0);
    chk("next_drain_addr", bus_if.BusAddr, 32'h104);
    e.addr = 32'h110; e.data = 32'hE0E0_0005;
    exp_q.push_back(e);
    cyc();
    MemWriteM = 1'b0;
    chk("fifth_count", 32'(u_dut.u_fifo.count), 32'd4);
    drain_all();

    // Forwarding picks the youngest of two stores to one address.
    rd0 = rd_cycles;
    put(32'h200, 32'h11);
    put(32'h200, 32'h22);
    MemReadM = 1'b1; ALUResultM = 32'h201;
    #1;
    chk("fwd_data", ReadDataM, 32'h22);
    chk("fwd_stall", 32'(StallMem), 32'd0);
    cyc();
    MemReadM = 1'b0;
    // Store and load together: the store wins, no read issued.
    MemWriteM = 1'b1; MemReadM = 1'b1; ALUResultM = 32'h600; WriteDataM = 32'h66;
    #1;
    chk("wr_rd_stall", 32'(StallMem), 32'd0);
    e.addr = 32'h600; e.data = 32'h66;
    exp_q.push_back(e);
    cyc();
    MemWriteM = 1'b0; MemReadM = 1'b0;
    drain_all();
    chk("fwd_no_bus_read", 32'(rd_cycles - rd0), 32'd0);

    // Load miss takes the bus ahead of two buffered stores.
    put(32'h400, 32'h4444_0000);
    put(32'h410, 32'h4444_0010);
    put(32'h416, 32'h4444_0014);
    MemReadM = 1'b1; ALUResultM = 32'h300; bus_if.BusAck = 1'b1;
    #1;
    chk("miss_stall_0", 32'(StallMem), 32'd1);
    chk("miss_rdata_0", ReadDataM, 32'd0);
    cyc();
    bus_if.BusAck = 1'b0;
    #1;
    chk("read_req", 32'(bus_if.BusReq), 32'd1);
    chk("read_we", 32'(bus_if.BusWe), 32'd0);
    chk("read_addr", bus_if.BusAddr, 32'h300);
    chk("read_pending_cnt", 32'(u_dut.u_fifo.count), 32'd2);
    chk("miss_stall_1", 32'(StallMem), 32'd1);
    cyc();
    chk("miss_stall_2", 32'(StallMem), 32'd1);
    cyc();
    bus_if.BusAck = 1'b1; bus_if.BusRData = 32'hDEAD_BEEF;
    #1;
    chk("miss_stall_3", 32'(StallMem), 32'd1);
    cyc();
    bus_if.BusAck = 1'b0; bus_if.BusRData = '0;
    #1;
    chk("rdone_stall", 32'(StallMem), 32'd0);
    chk("rdone_data", ReadDataM, 32'hDEAD_BEEF);
    cyc();
    MemReadM = 1'b0;
    #1;
    chk("resume_we", 32'(bus_if.BusWe), 32'd1);
    chk("resume_addr", bus_if.BusAddr, 32'h410);
    drain_all();

    // Push and pop together at count 2, across the tail wrap.
    put(32'h700, 32'h7000);
    put(32'h704, 32'h7004);
    chk("pp_start_cnt", 32'(u_dut.u_fifo.count), 32'd2);
    wrapped = 1'b0;
    for (int i = 0; i < 6; i++) begin
      prev_tail = u_dut.u_fifo.tail;
      MemWriteM = 1'b1; ALUResultM = 32'h708 + 32'(i * 4); WriteDataM = 32'h7100 + 32'(i);
      bus_if.BusAck = 1'b1;
      #1;
      chk("pp_stall", 32'(StallMem), 32'd0);
      e.addr = ALUResultM; e.data = WriteDataM;
      exp_q.push_back(e);
      cyc();
      if (u_dut.u_fifo.tail < prev_tail) wrapped = 1'b1;
      chk("pp_count", 32'(u_dut.u_fifo.count), 32'd2);
    end
    MemWriteM = 1'b0; bus_if.BusAck = 1'b0;
    chk("pp_tail_wrapped", 32'(wrapped), 32'd1);
    drain_all();

    // Reset during a drain drops everything buffered.
    put(32'h800, 32'h8000);
    put(32'h804, 32'h8004);
    put(32'h808, 32'h8008);
    chk("pre_rst_req", 32'(bus_if.BusReq), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus_if.BusReq), 32'd0);
    chk("mid_rst_count", 32'(u_dut.u_fifo.count), 32'd0);
    chk("mid_rst_addr", bus_if.BusAddr, 32'd0);
    chk("mid_rst_wdata", bus_if.BusWData, 32'd0);
    chk("mid_rst_stall", 32'(StallMem), 32'd0);
    exp_q.delete();
    nw0 = nwrites;
    bus_if.BusAck = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_if.BusAck = i[0];
      cyc();
    end
    bus_if.BusAck = 1'b0;
    chk("post_rst_req", 32'(bus_if.BusReq), 32'd0);
    chk("post_rst_writes", 32'(nwrites - nw0), 32'd0);
    chk("post_rst_count", 32'(u_dut.u_fifo.count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
